uplink_manchester_tx: RTL and testbench



---
 rtl/uplink_manchester_tx.sv | 79 +++++++
 tb/tb_uplink_manchester_tx.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/uplink_manchester_tx.sv
// uplink_manchester_tx: frames a word as sync + MSB-first Manchester data + odd parity, with a bit-centre transmit clock.
module uplink_manchester_tx #(
  parameter int DATA_WIDTH    = 16,
  parameter int HALF_BIT_CLKS = 25,
  parameter int GAP_BITS      = 2
) (
  input  logic                  CLK_100MHZ,
  input  logic                  nRst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  UpSig_Data,
  output logic                  UpSig_TClk,
  output logic                  tx_busy,
  output logic                  tx_done
);
  localparam int HW = $clog2(HALF_BIT_CLKS);
  typedef enum logic [2:0] {IDLE, SYNC, DATA, PARITY, GAP} state_t;
  state_t state, state_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [15:0] hidx, hidx_n, halves;
  logic [DATA_WIDTH-1:0] sreg, sreg_n;
  logic par, par_n, half_end, field_end, data_n, tclk_n;
  always_comb begin
    halves = state == SYNC ? 16'd6 : state == DATA ? 16'(2 * DATA_WIDTH) :
             state == PARITY ? 16'd2 : 16'(2 * GAP_BITS);
    half_end = hcnt == HW'(HALF_BIT_CLKS - 1);
    field_end = half_end && hidx == halves - 16'd1;
    state_n = state;
    hcnt_n = half_end ? '0 : hcnt + HW'(1);
    hidx_n = half_end ? (field_end ? '0 : hidx + 16'd1) : hidx;
    sreg_n = sreg;
    par_n = par;
    if (state == IDLE) begin
      hcnt_n = '0;
      hidx_n = '0;
      if (tx_valid && tx_ready) begin
        state_n = SYNC;
        sreg_n = tx_data;
        par_n = ~^tx_data;
      end
    end else if (field_end) begin
      if (state == SYNC) state_n = DATA;
      else if (state == DATA) state_n = PARITY;
      else if (state == PARITY && GAP_BITS > 0) state_n = GAP;
      else state_n = IDLE;
    end
    if (state == DATA && half_end && hidx[0] && !field_end) sreg_n = sreg << 1;
    data_n = state_n == SYNC ? hidx_n < 16'd3 :
             state_n == DATA ? sreg_n[DATA_WIDTH-1] ^ hidx_n[0] :
             state_n == PARITY ? par_n ^ hidx_n[0] : 1'b0;
    tclk_n = (state_n == DATA || state_n == PARITY) && !hidx_n[0];
  end
  always_ff @(posedge CLK_100MHZ) begin
    if (!nRst) begin
      state      <= IDLE;
      hcnt       <= '0;
      hidx       <= '0;
      sreg       <= '0;
      par        <= 1'b0;
      tx_ready   <= 1'b0;
      UpSig_Data <= 1'b0;
      UpSig_TClk <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      hcnt       <= hcnt_n;
      hidx       <= hidx_n;
      sreg       <= sreg_n;
      par        <= par_n;
      tx_ready   <= state_n == IDLE;
      UpSig_Data <= data_n;
      UpSig_TClk <= tclk_n;
      tx_busy    <= state_n != IDLE;
      tx_done    <= state == PARITY && state_n != PARITY;
    end
  end
endmodule

// File: tb/tb_uplink_manchester_tx.sv
// tb_uplink_manchester_tx: directed frames checked by a frame-decoding monitor against a queue of hand-computed words.
module tb_uplink_manchester_tx;
  localparam int F = 160;
  logic clk = 1'b0, nRst = 1'b0;
  logic [15:0] tx_data = '0, tx_data_z = '0;
  logic tx_valid = 1'b0, tx_valid_z = 1'b0;
  logic tx_ready, UpSig_Data, UpSig_TClk, tx_busy, tx_done;
  logic ready_z, data_z, tclk_z, busy_z, done_z;
  int nvec = 0, nmis = 0, frames_done = 0, done_cnt = 0, base, cnt;
  logic [16:0] exp_q[$];
  logic d_s[0:180], t_s[0:180], b_s[0:180], r_s[0:180], n_s[0:180];
  int m_bad, m_tbad, m_falls, m_dn, m_bb;
  logic [16:0] m_e, m_got;
  logic [23:0] m_sy;
  logic m_b, m_et;
  bit m_abort;

  always #5 clk = ~clk;

  uplink_manchester_tx #(.DATA_WIDTH(16), .HALF_BIT_CLKS(4), .GAP_BITS(2)) u_dut (
    .CLK_100MHZ(clk), .nRst(nRst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .UpSig_Data(UpSig_Data), .UpSig_TClk(UpSig_TClk), .tx_busy(tx_busy), .tx_done(tx_done));

  uplink_manchester_tx #(.DATA_WIDTH(16), .HALF_BIT_CLKS(4), .GAP_BITS(0)) u_nogap (
    .CLK_100MHZ(clk), .nRst(nRst), .tx_data(tx_data_z), .tx_valid(tx_valid_z), .tx_ready(ready_z),
    .UpSig_Data(data_z), .UpSig_TClk(tclk_z), .tx_busy(busy_z), .tx_done(done_z));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

  // Monitor: capture each frame from its first busy cycle and decode it off the line.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_busy === 1'b1) begin
        m_abort = 0;
        for (int c = 1; c <= F + 17; c++) begin
          if (c > 1) @(negedge clk);
          d_s[c] = UpSig_Data; t_s[c] = UpSig_TClk; b_s[c] = tx_busy; r_s[c] = tx_ready; n_s[c] = tx_done;
          if (tx_busy !== 1'b1 && c <= F + 16) begin m_abort = 1; break; end
        end
        if (!m_abort) begin
          if (exp_q.size() == 0) chk("unexpected frame", 0, 1);
          else begin
            m_e = exp_q.pop_front();
            m_sy = '0;
            for (int c = 1; c <= 24; c++) m_sy = {m_sy[22:0], d_s[c]};
            chk("sync header", m_sy, 24'hFFF000);
            m_bad = 0; m_got = '0;
            for (int i = 0; i <= 16; i++) begin
              m_b = d_s[25 + 8 * i];
              for (int j = 0; j < 4; j++)
                if (d_s[25 + 8 * i + j] !== m_b || d_s[29 + 8 * i + j] !== ~m_b) m_bad++;
              m_got = {m_got[15:0], m_b};
            end
            chk("payload+parity", m_got, m_e);
            chk("manchester halves", m_bad, 0);
            m_tbad = 0; m_falls = 0;
            for (int c = 1; c <= F + 17; c++) begin
              m_et = c >= 25 && c <= F && ((c - 25) % 8) < 4;
              if (t_s[c] !== m_et) m_tbad++;
              if (c > 1 && t_s[c - 1] === 1'b1 && t_s[c] === 1'b0) begin
                m_falls++;
                if (c < 25 || ((c - 25) % 8) != 4) m_tbad++;
              end
            end
            chk("tclk pattern", m_tbad, 0);
            chk("tclk falling edges", m_falls, 17);
            chk("done at F+1", n_s[F + 1], 1);
            m_dn = 0; m_bb = 0;
            for (int c = 1; c <= F + 17; c++) if (c != F + 1 && n_s[c] !== 1'b0) m_dn++;
            for (int c = 1; c <= F + 16; c++) if (b_s[c] !== 1'b1 || r_s[c] !== 1'b0) m_bb++;
            for (int c = F + 1; c <= F + 16; c++) if (d_s[c] !== 1'b0) m_bb++;
            chk("done elsewhere", m_dn, 0);
            chk("busy/ready/gap during frame", m_bb, 0);
            chk("idle after gap", {b_s[F + 17], r_s[F + 17]}, 2'b01);
          end
          frames_done++;
        end
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && k < 1000) begin @(negedge clk); k++; end
    chk("ready before send", tx_ready, 1);
  endtask

  task automatic send(input logic [15:0] w, input logic p);
    wait_ready();
    tx_data = w; tx_valid = 1'b1;
    exp_q.push_back({w, p});
    @(posedge clk); #1 tx_valid = 1'b0; tx_data = 16'hDEAD;
    @(negedge clk);
    chk("accept latency", {tx_busy, tx_ready, UpSig_Data}, 3'b101);
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 600 && frames_done < n; i++) @(negedge clk);
    chk("frame completed", frames_done, n);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {tx_ready, UpSig_Data, UpSig_TClk, tx_busy, tx_done}, 5'b0);
    nRst = 1'b1;
    @(negedge clk);
    chk("ready after reset", tx_ready, 1);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if ({UpSig_Data, UpSig_TClk, tx_busy, tx_done} !== 4'b0 || tx_ready !== 1'b1) cnt++;
    end
    chk("idle quiet", cnt, 0);

    send(16'hA5C3, 1'b1);
    wait_frames(1);
    send(16'h0001, 1'b0);
    wait_frames(2);

    wait_ready();
    base = done_cnt;
    tx_data = 16'h1234; tx_valid = 1'b1;
    exp_q.push_back({16'h1234, 1'b0});
    @(posedge clk); #1 tx_data = 16'hFFFF;
    exp_q.push_back({16'hFFFF, 1'b1});
    repeat (176) @(posedge clk);
    @(negedge clk);
    chk("b2b idle cycle 177", {tx_ready, tx_busy}, 2'b10);
    @(posedge clk); #1 tx_valid = 1'b0;
    @(negedge clk);
    chk("b2b sync at 178", {tx_busy, UpSig_Data, tx_ready}, 3'b110);
    wait_frames(4);
    repeat (30) @(negedge clk);
    chk("b2b done pulses", done_cnt - base, 2);

    wait_ready();
    base = done_cnt;
    tx_data = 16'h5A5A; tx_valid = 1'b1;
    @(posedge clk); #1 tx_valid = 1'b0;
    repeat (59) @(posedge clk);
    #1 nRst = 1'b0;
    @(posedge clk); #1 nRst = 1'b1;
    @(negedge clk);
    chk("mid-frame reset outputs", {tx_ready, UpSig_Data, UpSig_TClk, tx_busy, tx_done}, 5'b0);
    @(negedge clk);
    chk("ready after mid reset", {tx_ready, tx_busy}, 2'b10);
    repeat (40) @(negedge clk);
    chk("no done after abort", done_cnt - base, 0);
    send(16'h8001, 1'b1);
    wait_frames(5);

    @(negedge clk);
    chk("nogap ready", ready_z, 1);
    tx_data_z = 16'hC3A5; tx_valid_z = 1'b1;
    @(posedge clk); #1 tx_valid_z = 1'b0; tx_data_z = 16'h1111;
    for (int c = 1; c <= 160; c++) begin
      @(negedge clk);
      if (c == 153) chk("nogap parity first half", data_z, 1);
      if (c == 157) chk("nogap parity second half", data_z, 0);
    end
    chk("nogap cycle 160", {busy_z, ready_z, done_z}, 3'b100);
    @(negedge clk);
    chk("nogap cycle 161", {done_z, ready_z, busy_z}, 3'b110);
    tx_data_z = 16'h7777; tx_valid_z = 1'b1;
    @(posedge clk); #1 tx_valid_z = 1'b0;
    @(negedge clk);
    chk("nogap sync at 162", {busy_z, data_z, ready_z, done_z}, 4'b1100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
